relay_bank: RTL and testbench
=============================

Name: relay_bank

Overview:
- Parametrised, clocked bank of N electromechanical relay models, generalising the single combinational relay (contact output = coil switch AND battery).
- Each channel adds pull-in and drop-out timing, contact-bounce rejection, a selectable normally-open/normally-closed contact, and a saturating closure counter.
- Used as the timing-accurate relay primitive under the team's relay-logic gates (inverter, AND/OR chains, oscillator) and their benches.

Parameters:
- N, 4, number of relay channels (>=1).
- PULL_IN, 3, consecutive sampled-high clocks of switch needed to close the armature (>=1).
- DROP_OUT, 2, consecutive sampled-low clocks of switch needed to open the armature (>=1).
- NC_MASK, {N{1'b0}}, per-channel contact type: bit=1 gives a normally-closed contact (Petzold inverter), 0 gives normally-open.
- CNT_W, 4, width of each per-channel closure counter.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high.
- switch  input  N  coil drive per channel, sampled on clk.
- batt  input  N  supply presented to each contact.
- clr_cnt  input  1  synchronous clear of all closure counters.
- c  output  N  contact output per channel.
- closed  output  N  registered armature state (1 = pulled in).
- ops  output  N*CNT_W  closure counters, channel i at bits [i*CNT_W +: CNT_W].

Behaviour:
- Interface (decided): one clock, clk; reset is asynchronous and active-high, port name reset.
- Reset (asserted at any time, including mid-count): all channels enter OPEN, counters and timers cleared. Outputs: closed=0, ops=0, c[i]=NC_MASK[i] & batt[i].
- Per-channel FSM, evaluated on each rising clk edge. States: OPEN, PULLING, CLOSED, RELEASING.
  - OPEN: switch=1 -> PULLING, timer=1; if PULL_IN==1, go to CLOSED directly instead.
  - PULLING: switch=0 -> OPEN, timer cleared (bounce rejected). Else timer+1; on reaching PULL_IN -> CLOSED.
  - CLOSED: switch=0 -> RELEASING, timer=1; if DROP_OUT==1, go to OPEN directly instead.
  - RELEASING: switch=1 -> CLOSED, timer cleared, no new closure counted. Else timer+1; on reaching DROP_OUT -> OPEN.
- closed[i]=1 in CLOSED and RELEASING, 0 otherwise.
  - Rises on the PULL_IN-th consecutive edge sampling switch=1.
  - Falls on the DROP_OUT-th consecutive edge sampling switch=0.
- c[i] = batt[i] & (closed[i] ^ NC_MASK[i]). This is combinational from batt (zero latency, like a real contact) and registered from the coil.
- ops[i] increments by 1 on each OPEN/PULLING -> CLOSED transition and saturates at 2^CNT_W-1 (no wrap).
- clr_cnt zeroes all counters at the edge. If clr_cnt coincides with a closure on the same edge, clear wins: result 0.
- Timer width: $clog2(max(PULL_IN,DROP_OUT)+1). The timer never exceeds its terminal value.
- Channels are fully independent. Simultaneous events across channels need no arbitration.

Decomposition:
- Shared package relay_pkg holds:
  - the state enum (OPEN, PULLING, CLOSED, RELEASING);
  - a function computing the timer width from PULL_IN and DROP_OUT.
- One sub-module, relay_channel, implements a single channel: FSM, timer, saturating counter, contact output.
- relay_bank generate-instantiates N copies, passing NC_MASK[i] to each.

Test Plan:
Defaults for all scenarios: N=4, PULL_IN=3, DROP_OUT=2, NC_MASK=4'b1000, CNT_W=4.
- Reset, batt=4'hF, switch=0 -> c=4'b1000, closed=0, ops=0. Re-asserting reset while channel 0 is in PULLING returns it to OPEN immediately, c[0]=0.
- switch[0]=1 from edge 0, batt[0]=1 -> closed[0]=1 and c[0]=1 after edge 2 (3rd edge), ops[0]=1. Toggling batt[0] to 0 drops c[0] combinationally while closed[0] stays 1.
- Bounce on channel 1: switch[1]=1 for 2 edges then 0 -> closed[1] never rises, ops[1]=0. A further 3 consecutive highs -> closes, ops[1]=1.
- Release on channel 0 (closed): switch low 1 edge then high -> closed[0] stays 1, ops[0] unchanged at 1. Switch low 2 edges -> closed[0]=0 after 2nd edge.
- NC channel 3, batt[3]=1: switch[3] held high -> c[3] goes 1 to 0 after 3rd edge. Switch[3] low -> c[3] returns to 1 after 2nd low edge.
- Channel 2 cycled through 17 full closures -> ops[2]=15 (saturated). Then clr_cnt asserted on the same edge as an 18th closure -> ops[2]=0.

Source files
------------

// File: rtl/relay_pkg.sv
// Shared types and helpers for the clocked relay bank: armature states and timer sizing.
package relay_pkg;

    typedef enum logic [1:0] {
        OPEN      = 2'd0,
        PULLING   = 2'd1,
        CLOSED    = 2'd2,
        RELEASING = 2'd3
    } relay_state_t;

    // Wide enough to hold the larger of the two terminal counts.
    function automatic int timer_width(input int pull_in, input int drop_out);
        int m;
        m = (pull_in > drop_out) ? pull_in : drop_out;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/relay_channel.sv
// One relay: pull-in/drop-out debounce FSM, saturating closure counter and contact output.
module relay_channel
    import relay_pkg::*;
#(
    parameter int   PULL_IN  = 3,
    parameter int   DROP_OUT = 2,
    parameter logic NC       = 1'b0,
    parameter int   CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             switch,
    input  logic             batt,
    input  logic             clr_cnt,
    output logic             c,
    output logic [1:0]       state_dbg,
    output logic [CNT_W-1:0] ops
);

    localparam int TW = timer_width(PULL_IN, DROP_OUT);

    relay_state_t  state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic          closing;
    logic          closed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= OPEN;
            timer <= '0;
        end else begin
            state <= state_n;
            timer <= timer_n;
        end
    end

    always_comb begin
        state_n = state;
        timer_n = timer;
        closing = 1'b0;
        case (state)
            OPEN: begin
                if (switch) begin
                    if (PULL_IN == 1) begin
                        state_n = CLOSED;
                        timer_n = '0;
                        closing = 1'b1;
                    end else begin
                        state_n = PULLING;
                        timer_n = TW'(1);
                    end
                end
            end
            PULLING: begin
                if (!switch) begin
                    state_n = OPEN;
                    timer_n = '0;
                end else if (timer == TW'(PULL_IN - 1)) begin
                    state_n = CLOSED;
                    timer_n = '0;
                    closing = 1'b1;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            CLOSED: begin
                if (!switch) begin
                    if (DROP_OUT == 1) begin
                        state_n = OPEN;
                        timer_n = '0;
                    end else begin
                        state_n = RELEASING;
                        timer_n = TW'(1);
                    end
                end
            end
            RELEASING: begin
                // A coil re-energised during drop-out keeps the armature in; not a new closure.
                if (switch) begin
                    state_n = CLOSED;
                    timer_n = '0;
                end else if (timer == TW'(DROP_OUT - 1)) begin
                    state_n = OPEN;
                    timer_n = '0;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            default: begin
                state_n = OPEN;
                timer_n = '0;
            end
        endcase
    end

    // Clear takes priority over a closure landing on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ops <= '0;
        end else if (clr_cnt) begin
            ops <= '0;
        end else if (closing && (ops != '1)) begin
            ops <= ops + 1'b1;
        end
    end

    assign closed    = (state == CLOSED) || (state == RELEASING);
    assign c         = batt & (closed ^ NC);
    assign state_dbg = state;

endmodule

// File: rtl/relay_bank.sv
// Bank of N independent timed relay channels with per-channel NO/NC contacts.
module relay_bank
    import relay_pkg::*;
#(
    parameter int         N        = 4,
    parameter int         PULL_IN  = 3,
    parameter int         DROP_OUT = 2,
    parameter logic [N-1:0] NC_MASK = {N{1'b0}},
    parameter int         CNT_W    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       switch,
    input  logic [N-1:0]       batt,
    input  logic               clr_cnt,
    output logic [N-1:0]       c,
    output logic [N-1:0]       closed,
    output logic [N*CNT_W-1:0] ops
);

    logic [1:0] state_dbg [N];

    for (genvar i = 0; i < N; i++) begin : g_ch
        relay_channel #(
            .PULL_IN (PULL_IN),
            .DROP_OUT(DROP_OUT),
            .NC      (NC_MASK[i]),
            .CNT_W   (CNT_W)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .switch   (switch[i]),
            .batt     (batt[i]),
            .clr_cnt  (clr_cnt),
            .c        (c[i]),
            .state_dbg(state_dbg[i]),
            .ops      (ops[i*CNT_W +: CNT_W])
        );

        assign closed[i] = (state_dbg[i] == CLOSED) || (state_dbg[i] == RELEASING);
    end

endmodule

// File: tb/tb_relay_bank.sv
// Directed bench for relay_bank: driver pushes expected outputs, negedge monitor compares.
module tb_relay_bank;

    localparam int N     = 4;
    localparam int CNT_W = 4;
    localparam int W     = N + N + N * CNT_W;

    logic               clk;
    logic               reset;
    logic [N-1:0]       switch;
    logic [N-1:0]       batt;
    logic               clr_cnt;
    logic [N-1:0]       c;
    logic [N-1:0]       closed;
    logic [N*CNT_W-1:0] ops;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           vectors;
    int           miscompares;

    relay_bank #(
        .N       (N),
        .PULL_IN (3),
        .DROP_OUT(2),
        .NC_MASK (4'b1000),
        .CNT_W   (CNT_W)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .switch (switch),
        .batt   (batt),
        .clr_cnt(clr_cnt),
        .c      (c),
        .closed (closed),
        .ops    (ops)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [W-1:0] mk(input logic [3:0] ec, input logic [3:0] ecl,
                                        input logic [15:0] eops);
        return {ec, ecl, eops};
    endfunction

    // driver: inputs for the next edge, then expected outputs after that edge
    task automatic cyc(input logic [3:0] sw, input logic [3:0] bt, input logic clr,
                       input logic [W-1:0] exp, input string nm);
        switch  = sw;
        batt    = bt;
        clr_cnt = clr;
        @(posedge clk);
        #1;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        @(negedge clk);
        #1;
    endtask

    // asynchronous reset pulse placed entirely between two rising edges
    task automatic rst_pulse();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [W-1:0] e;
            logic [W-1:0] g;
            string        n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            g = {c, closed, ops};
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL %s: got c=%b closed=%b ops=%h, expected c=%b closed=%b ops=%h",
                         n, g[W-1 -: 4], g[W-5 -: 4], g[15:0], e[W-1 -: 4], e[W-5 -: 4], e[15:0]);
            end
        end
    end

    initial begin
        logic [3:0] o2;
        vectors     = 0;
        miscompares = 0;
        reset   = 1'b1;
        switch  = '0;
        batt    = 4'hF;
        clr_cnt = 1'b0;

        // reset state
        cyc(4'b0000, 4'hF, 1'b0, mk(4'b1000, 4'b0000, 16'h0000), "reset_hold_a");
        cyc(4'b0000, 4'hF, 1'b0, mk(4'b1000, 4'b0000, 16'h0000), "reset_hold_b");
        reset = 1'b0;

        // ch0 pulling, then async reset mid-count restarts the pull-in
        cyc(4'b0001, 4'hF, 1'b0, mk(4'b1000, 4'b0000, 16'h0000), "pull0_e1");
        cyc(4'b0001, 4'hF, 1'b0, mk(4'b1000, 4'b0000, 16'h0000), "pull0_e2");
        rst_pulse();
        cyc(4'b0001, 4'hF, 1'b0, mk(4'b1000, 4'b0000, 16'h0000), "after_rst_e1");
        cyc(4'b0001, 4'hF, 1'b0, mk(4'b1000, 4'b0000, 16'h0000), "after_rst_e2");
        cyc(4'b0001, 4'hF, 1'b0, mk(4'b1001, 4'b0001, 16'h0001), "ch0_closed");
        cyc(4'b0001, 4'hE, 1'b0, mk(4'b1000, 4'b0001, 16'h0001), "ch0_batt_off");
        cyc(4'b0001, 4'hF, 1'b0, mk(4'b1001, 4'b0001, 16'h0001), "ch0_batt_on");

        // bounce on ch1 is rejected, then a clean pull-in closes it
        cyc(4'b0011, 4'hF, 1'b0, mk(4'b1001, 4'b0001, 16'h0001), "bounce1_e1");
        cyc(4'b0011, 4'hF, 1'b0, mk(4'b1001, 4'b0001, 16'h0001), "bounce1_e2");
        cyc(4'b0001, 4'hF, 1'b0, mk(4'b1001, 4'b0001, 16'h0001), "bounce1_drop");
        cyc(4'b0011, 4'hF, 1'b0, mk(4'b1001, 4'b0001, 16'h0001), "pull1_e1");
        cyc(4'b0011, 4'hF, 1'b0, mk(4'b1001, 4'b0001, 16'h0001), "pull1_e2");
        cyc(4'b0011, 4'hF, 1'b0, mk(4'b1011, 4'b0011, 16'h0011), "ch1_closed");

        // ch0 release glitch, then full drop-out
        cyc(4'b0010, 4'hF, 1'b0, mk(4'b1011, 4'b0011, 16'h0011), "rel0_glitch");
        cyc(4'b0011, 4'hF, 1'b0, mk(4'b1011, 4'b0011, 16'h0011), "rel0_recover");
        cyc(4'b0010, 4'hF, 1'b0, mk(4'b1011, 4'b0011, 16'h0011), "rel0_e1");
        cyc(4'b0010, 4'hF, 1'b0, mk(4'b1010, 4'b0010, 16'h0011), "ch0_opened");
        cyc(4'b0000, 4'hF, 1'b0, mk(4'b1010, 4'b0010, 16'h0011), "rel1_e1");
        cyc(4'b0000, 4'hF, 1'b0, mk(4'b1000, 4'b0000, 16'h0011), "ch1_opened");

        // normally-closed ch3
        cyc(4'b1000, 4'hF, 1'b0, mk(4'b1000, 4'b0000, 16'h0011), "nc3_e1");
        cyc(4'b1000, 4'hF, 1'b0, mk(4'b1000, 4'b0000, 16'h0011), "nc3_e2");
        cyc(4'b1000, 4'hF, 1'b0, mk(4'b0000, 4'b1000, 16'h1011), "nc3_closed");
        cyc(4'b0000, 4'hF, 1'b0, mk(4'b0000, 4'b1000, 16'h1011), "nc3_rel_e1");
        cyc(4'b0000, 4'hF, 1'b0, mk(4'b1000, 4'b0000, 16'h1011), "nc3_opened");

        // ch2 closure counter up to saturation
        for (int k = 1; k <= 17; k++) begin
            o2 = (k - 1 > 15) ? 4'd15 : 4'(k - 1);
            cyc(4'b0100, 4'hF, 1'b0, mk(4'b1000, 4'b0000, {4'h1, o2, 8'h11}), "sat2_e1");
            cyc(4'b0100, 4'hF, 1'b0, mk(4'b1000, 4'b0000, {4'h1, o2, 8'h11}), "sat2_e2");
            o2 = (k > 15) ? 4'd15 : 4'(k);
            cyc(4'b0100, 4'hF, 1'b0, mk(4'b1100, 4'b0100, {4'h1, o2, 8'h11}), "sat2_close");
            cyc(4'b0000, 4'hF, 1'b0, mk(4'b1100, 4'b0100, {4'h1, o2, 8'h11}), "sat2_rel");
            cyc(4'b0000, 4'hF, 1'b0, mk(4'b1000, 4'b0000, {4'h1, o2, 8'h11}), "sat2_open");
        end

        // clear coinciding with the 18th closure wins, then counting resumes
        cyc(4'b0100, 4'hF, 1'b0, mk(4'b1000, 4'b0000, 16'h1F11), "clr_e1");
        cyc(4'b0100, 4'hF, 1'b0, mk(4'b1000, 4'b0000, 16'h1F11), "clr_e2");
        cyc(4'b0100, 4'hF, 1'b1, mk(4'b1100, 4'b0100, 16'h0000), "clr_with_close");
        cyc(4'b0000, 4'hF, 1'b0, mk(4'b1100, 4'b0100, 16'h0000), "post_clr_rel");
        cyc(4'b0000, 4'hF, 1'b0, mk(4'b1000, 4'b0000, 16'h0000), "post_clr_open");
        cyc(4'b0100, 4'hF, 1'b0, mk(4'b1000, 4'b0000, 16'h0000), "recount_e1");
        cyc(4'b0100, 4'hF, 1'b0, mk(4'b1000, 4'b0000, 16'h0000), "recount_e2");
        cyc(4'b0100, 4'hF, 1'b0, mk(4'b1100, 4'b0100, 16'h0100), "recount_close");

        // drain the scoreboard with a bounded wait
        for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, expected 0 pending", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
